fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the RV32I pipeline.
- Holds the PC and drives the instruction-memory (I-cache) read handshake.
- Buffers fetched {pc, instr} pairs in a small FIFO and presents them to decode, where the instruction word feeds the decode translator.
- Handles control-flow redirects from execute, including redirects that arrive while a memory request is still outstanding.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- RESET_PC, 32'h4000_0000, PC loaded on reset.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- imem_address  output  32  fetch address, word aligned
- imem_read  output  1  read request
- imem_rdata  input  32  instruction word, valid when imem_resp=1
- imem_resp  input  1  one-cycle completion pulse
- redirect  input  1  flush and refetch from redirect_pc
- redirect_pc  input  32  redirect target, word aligned
- id_ready  input  1  decode accepts the head entry this cycle
- if_valid  output  1  head entry valid
- if_instr  output  32  head instruction word
- if_pc  output  32  head PC

Behaviour:
- Reset: synchronous, active-high (rst); clock clk.
  - pc=RESET_PC, FIFO empty, state=S_REQ.
  - if_valid=0, imem_read=1, imem_address=RESET_PC from the first cycle after reset.
  - rst asserted mid-request abandons the request: no wait for imem_resp, and any later response is not captured.
- Memory protocol:
  - imem_read and imem_address stay stable from assertion until the cycle imem_resp=1.
  - At most one request is outstanding.
  - A request is never withdrawn early.
- State S_REQ: request outstanding at pc.
  - On imem_resp without redirect: enqueue {pc, imem_rdata} and set pc=pc+4 (mod 2^32).
  - If the FIFO will be full next cycle (count_next==DEPTH), go to S_HOLD with imem_read=0.
  - Otherwise stay in S_REQ and issue the next request the following cycle (back-to-back allowed).
- State S_HOLD: FIFO full, no request outstanding.
  - When count_next<DEPTH (a dequeue occurred), go to S_REQ.
- State S_FLUSH: redirect arrived while a request was outstanding.
  - Keep imem_read and the old address asserted.
  - When imem_resp arrives, discard the data, set pc=pend_pc, and go to S_REQ.
- Redirect (priority over all other events):
  - The FIFO is cleared at the clock edge.
  - if_valid is forced 0 in the redirect cycle; any dequeue that cycle is void.
  - In S_REQ without imem_resp: latch pend_pc=redirect_pc and go to S_FLUSH.
  - In S_REQ with imem_resp in the same cycle: discard the data, set pc=redirect_pc, stay in S_REQ; next request is at redirect_pc.
  - In S_FLUSH: overwrite pend_pc; the newest target wins.
  - In S_HOLD: set pc=redirect_pc and go to S_REQ.
- FIFO:
  - Registered storage.
  - if_valid = (count!=0) & ~redirect.
  - if_instr and if_pc come from the head entry.
  - Dequeue when if_valid & id_ready.
  - Enqueue and dequeue in the same cycle are legal, including when count==DEPTH (state is S_HOLD, so no enqueue is possible) and count==0 (no dequeue is possible).
  - Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Latency: data with imem_resp appears on the outputs (if_valid=1) the next cycle.
- Outputs are held stable while if_valid=1 and id_ready=0.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds two outputs, both cleared by rst and saturating at all-ones.
  - perf_wait_cycles, output, 32: counts cycles with imem_read=1 and imem_resp=0.
  - perf_flush_count, output, 32: counts redirect cycles.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- rv32i_types package:
  - fetch_entry_t struct {rv32i_word pc; rv32i_word instr}
  - fetch_state_t enum {S_REQ, S_HOLD, S_FLUSH}
  - RESET_PC default constant
- Sub-module fetch_fifo, parameterised by DEPTH, storing fetch_entry_t.
  - Ports: enq, enq_data, deq, flush, head, count, empty, full.
  - Flush has priority over enqueue and dequeue.

Test Plan:
- Reset, id_ready=1, memory responds 1 cycle after each read with data=address^32'hFFFF_FFFF:
  - Addresses 0x40000000, 0x40000004, 0x40000008 in order.
  - if_pc/if_instr match one cycle after each imem_resp.
- id_ready=0 with DEPTH=4:
  - Exactly 4 responses are accepted, then imem_read=0.
  - Raising id_ready for 1 cycle pops 0x40000000; imem_read reasserts at 0x40000010 the next cycle.
- Redirect to 0x40001000 while a request at 0x40000008 is outstanding (resp delayed 5 cycles):
  - imem_address stays 0x40000008 until resp.
  - That data never appears; the next request is 0x40001000.
  - if_valid=0 throughout.
- Redirect to 0x40002000 in the same cycle as imem_resp:
  - Response discarded; next cycle imem_address=0x40002000.
- Two redirects during one outstanding request (0x40003000, then 0x40004000):
  - Only 0x40004000 is fetched.
- rst asserted mid-request and mid-flush:
  - FIFO empty; next request at 0x40000000.
  - With FETCH_PERF_EN, both counters read 0.

Source files
------------

// File: rtl/rv32i_types.sv
// -----------------------------------------------------------------------------
// rv32i_types
//
// Shared types and constants for the RV32I front end.
//
//   rv32i_word       32-bit architectural word (addresses and instructions)
//   fetch_entry_t    {pc, instr} pair buffered between fetch and decode
//   fetch_state_t    fetch controller states:
//                      S_REQ   - a memory request is outstanding at pc
//                      S_HOLD  - the fetch buffer is full, nothing outstanding
//                      S_FLUSH - a redirect arrived while a request was in
//                                flight; the stale response is still awaited
//   RESET_PC_DEFAULT default PC loaded on reset
// -----------------------------------------------------------------------------
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef struct packed {
        rv32i_word pc;
        rv32i_word instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_t;

    localparam rv32i_word RESET_PC_DEFAULT = 32'h4000_0000;

    // Sequential fetch advances one 32-bit instruction at a time; the add
    // wraps modulo 2^32.
    function automatic rv32i_word next_pc(input rv32i_word pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//
// Small registered FIFO holding fetched {pc, instr} pairs for decode.
// DEPTH must be a power of two and at least 2, so the read and write pointers
// wrap naturally and count needs exactly one extra bit to represent "full".
//
// Ports
//   clk, rst   clock, synchronous active-high reset
//   enq        push enq_data (ignored when full unless a pop happens too)
//   enq_data   entry to push
//   deq        pop the head entry (ignored when empty)
//   flush      empty the FIFO; wins over enq and deq in the same cycle
//   head       entry at the head of the FIFO (meaningless when empty)
//   count      number of valid entries, 0..DEPTH
//   empty      count == 0
//   full       count == DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo
    import rv32i_types::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq,
    input  fetch_entry_t             enq_data,
    input  logic                     deq,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_do_enq;
    logic             w_do_deq;

    assign empty    = (r_count == '0);
    assign full     = (r_count == CW'(DEPTH));
    assign count    = r_count;
    assign head     = r_mem[r_rd_ptr];

    // A push into a full FIFO is only legal when a pop frees the slot
    // in the same cycle.
    assign w_do_deq = deq & ~empty;
    assign w_do_enq = enq & (~full | w_do_deq);

    // NOTE: the storage array has no reset. Entries are only observed through
    // the pointers/count, which are reset, so clearing the data would just add
    // a reset fan-out to every storage bit for no functional gain.
    always_ff @(posedge clk) begin
        if (w_do_enq && !flush) begin
            r_mem[r_wr_ptr] <= enq_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register in the design samples its inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_do_enq) - CW'(w_do_deq);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage of the RV32I pipeline. Holds the PC, drives the
// instruction-memory read handshake (at most one request outstanding, never
// withdrawn early), buffers fetched {pc, instr} pairs in a fetch_fifo and
// presents the head entry to decode. Redirects from execute flush the buffer;
// a redirect that lands while a request is in flight waits for that stale
// response (S_FLUSH) before fetching from the new target.
//
// Parameters
//   DEPTH      fetch buffer entries (power of two, >= 2)
//   RESET_PC   PC loaded on reset
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   imem_address  out  fetch address (word aligned), stable while imem_read=1
//   imem_read     out  read request
//   imem_rdata    in   instruction word, valid with imem_resp
//   imem_resp     in   one-cycle completion pulse
//   redirect      in   flush and refetch from redirect_pc
//   redirect_pc   in   redirect target (word aligned)
//   id_ready      in   decode accepts the head entry this cycle
//   if_valid      out  head entry valid
//   if_instr      out  head instruction word
//   if_pc         out  head PC
//
// Optional build macro FETCH_PERF_EN adds two saturating 32-bit counters,
// cleared by rst:
//   perf_wait_cycles  out  cycles with imem_read=1 and imem_resp=0
//   perf_flush_count  out  cycles with redirect=1
// -----------------------------------------------------------------------------
module fetch_unit
    import rv32i_types::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic        clk,
    input  logic        rst,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_wait_cycles,
    output logic [31:0] perf_flush_count,
`endif
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    // -------------------------------------------------------------------------
    // Controller state
    // -------------------------------------------------------------------------
    fetch_state_t  r_state;
    logic [31:0]   r_pc;        // address of the outstanding / next request
    logic [31:0]   r_pend_pc;   // redirect target parked during S_FLUSH
    logic          r_imem_read;

    // -------------------------------------------------------------------------
    // Fetch buffer
    // -------------------------------------------------------------------------
    fetch_entry_t  w_enq_data;
    fetch_entry_t  w_head;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_next;
    logic          w_empty;
    logic          w_full;
    logic          w_enq;
    logic          w_deq;
    logic          w_if_valid;

    // A redirect squashes the head in the same cycle, which also voids any
    // dequeue decode might have attempted.
    assign w_if_valid = ~w_empty & ~redirect;
    assign w_deq      = w_if_valid & id_ready;

    // Only a response to a live (non-flushed) request is buffered.
    assign w_enq      = (r_state == S_REQ) & imem_resp & ~redirect
                        & (~w_full | w_deq);

    assign w_enq_data = '{pc: r_pc, instr: imem_rdata};

    // Occupancy after this edge; drives the S_REQ <-> S_HOLD decisions.
    assign w_count_next = redirect ? '0
                                   : (w_count + CW'(w_enq) - CW'(w_deq));

    fetch_fifo #(
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .enq      (w_enq),
        .enq_data (w_enq_data),
        .deq      (w_deq),
        .flush    (redirect),
        .head     (w_head),
        .count    (w_count),
        .empty    (w_empty),
        .full     (w_full)
    );

    // -------------------------------------------------------------------------
    // Fetch FSM. imem_read is registered alongside the state so the request
    // line only changes at the edge where a request starts or completes, and
    // imem_address is simply the PC register, which is frozen while a request
    // (including a flushed one) is outstanding.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_pend_pc   <= RESET_PC;
            r_imem_read <= 1'b1;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (redirect) begin
                        if (imem_resp) begin
                            // Stale data dropped; request the target next.
                            r_pc <= redirect_pc;
                        end else begin
                            // Request still in flight: wait it out first.
                            r_pend_pc <= redirect_pc;
                            r_state   <= S_FLUSH;
                        end
                    end else if (imem_resp) begin
                        r_pc <= next_pc(r_pc);
                        if (w_count_next == CW'(DEPTH)) begin
                            r_state     <= S_HOLD;
                            r_imem_read <= 1'b0;
                        end
                    end
                end

                S_HOLD: begin
                    if (redirect) begin
                        r_pc        <= redirect_pc;
                        r_state     <= S_REQ;
                        r_imem_read <= 1'b1;
                    end else if (w_count_next < CW'(DEPTH)) begin
                        r_state     <= S_REQ;
                        r_imem_read <= 1'b1;
                    end
                end

                S_FLUSH: begin
                    if (imem_resp) begin
                        // Newest redirect target wins, even one arriving
                        // together with the stale response.
                        r_pc    <= redirect ? redirect_pc : r_pend_pc;
                        r_state <= S_REQ;
                    end else if (redirect) begin
                        r_pend_pc <= redirect_pc;
                    end
                end

                default: begin
                    r_state     <= S_REQ;
                    r_imem_read <= 1'b1;
                end
            endcase
        end
    end

    assign imem_read    = r_imem_read;
    assign imem_address = r_pc;

    assign if_valid     = w_if_valid;
    assign if_pc        = w_head.pc;
    assign if_instr     = w_head.instr;

`ifdef FETCH_PERF_EN
    // -------------------------------------------------------------------------
    // Performance counters (saturating)
    // -------------------------------------------------------------------------
    logic [31:0] r_perf_wait;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_wait  <= '0;
            r_perf_flush <= '0;
        end else begin
            if (r_imem_read && !imem_resp && !(&r_perf_wait)) begin
                r_perf_wait <= r_perf_wait + 32'd1;
            end
            if (redirect && !(&r_perf_flush)) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_wait_cycles = r_perf_wait;
    assign perf_flush_count = r_perf_flush;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit (DEPTH=4, RESET_PC=0x4000_0000). Each cycle
// record holds the inputs to drive and the outputs expected in that same
// cycle (sampled after the inputs settle, mid-cycle). The memory responds by
// hand in the vectors with data = address ^ 0xFFFF_FFFF.
// Build with +define+FETCH_PERF_EN to also cover the performance counters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] A0  = 32'h4000_0000;
    localparam logic [31:0] A4  = 32'h4000_0004;
    localparam logic [31:0] A8  = 32'h4000_0008;
    localparam logic [31:0] AC  = 32'h4000_000C;
    localparam logic [31:0] A10 = 32'h4000_0010;
    localparam logic [31:0] R1  = 32'h4000_1000;
    localparam logic [31:0] R2  = 32'h4000_2000;
    localparam logic [31:0] R3  = 32'h4000_3000;
    localparam logic [31:0] R4  = 32'h4000_4000;

    logic        clk;
    logic        rst;
    logic [31:0] imem_address;
    logic        imem_read;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_wait_cycles;
    logic [31:0] perf_flush_count;
`endif

    int checks   = 0;
    int failures = 0;

    fetch_unit #(
        .DEPTH            (4),
        .RESET_PC         (A0)
    ) dut (
        .clk              (clk),
        .rst              (rst),
`ifdef FETCH_PERF_EN
        .perf_wait_cycles (perf_wait_cycles),
        .perf_flush_count (perf_flush_count),
`endif
        .imem_address     (imem_address),
        .imem_read        (imem_read),
        .imem_rdata       (imem_rdata),
        .imem_resp        (imem_resp),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .id_ready         (id_ready),
        .if_valid         (if_valid),
        .if_instr         (if_instr),
        .if_pc            (if_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        resp;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        chk;
        logic        e_read;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst_i, input logic resp_i,
                                input logic [31:0] rdata_i, input logic redir_i,
                                input logic [31:0] rpc_i, input logic rdy_i,
                                input logic chk_i, input logic e_read_i,
                                input logic [31:0] e_addr_i, input logic e_valid_i,
                                input logic [31:0] e_pc_i);
        vec_t v;
        v.rst     = rst_i;
        v.resp    = resp_i;
        v.rdata   = rdata_i;
        v.redir   = redir_i;
        v.rpc     = rpc_i;
        v.rdy     = rdy_i;
        v.chk     = chk_i;
        v.e_read  = e_read_i;
        v.e_addr  = e_addr_i;
        v.e_valid = e_valid_i;
        v.e_pc    = e_pc_i;
        v.e_instr = ~e_pc_i;   // memory model: data = address ^ all-ones
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle: inputs at the falling edge, compare 1ns later.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst         = v.rst;
        imem_resp   = v.resp;
        imem_rdata  = v.rdata;
        redirect    = v.redir;
        redirect_pc = v.rpc;
        id_ready    = v.rdy;
        #1;
        if (v.chk) begin
            check({tag, " imem_read"}, {31'd0, imem_read}, {31'd0, v.e_read});
            if (v.e_read) begin
                check({tag, " imem_address"}, imem_address, v.e_addr);
            end
            check({tag, " if_valid"}, {31'd0, if_valid}, {31'd0, v.e_valid});
            if (v.e_valid) begin
                check({tag, " if_pc"}, if_pc, v.e_pc);
                check({tag, " if_instr"}, if_instr, v.e_instr);
            end
        end
    endtask

    // Hand-written cycle: rst=0, data always address^all-ones of rd_addr.
    task automatic cyc(input string tag, input logic resp, input logic [31:0] rd_addr,
                       input logic redir, input logic [31:0] rpc, input logic rdy,
                       input logic e_read, input logic [31:0] e_addr,
                       input logic e_valid, input logic [31:0] e_pc);
        apply(mk(1'b0, resp, ~rd_addr, redir, rpc, rdy, 1'b1,
                 e_read, e_addr, e_valid, e_pc), tag);
    endtask

    task automatic do_reset(input logic rdy);
        apply(mk(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, rdy, 1'b0,
                 1'b0, 32'd0, 1'b0, 32'd0), "reset");
    endtask

    initial begin
        rst = 1'b1; imem_resp = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;

        // ---------------- table: streaming and buffer-full ----------------
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // id_ready=1, response one cycle after each request
        tbl.push_back(mk(0, 0, 0,   0, 0, 1, 1, 1, A0, 0, 0));
        tbl.push_back(mk(0, 1, ~A0, 0, 0, 1, 1, 1, A0, 0, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 1, 1, 1, A4, 1, A0));
        tbl.push_back(mk(0, 1, ~A4, 0, 0, 1, 1, 1, A4, 0, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 1, 1, 1, A8, 1, A4));
        tbl.push_back(mk(0, 1, ~A8, 0, 0, 1, 1, 1, A8, 0, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 1, 1, 1, AC, 1, A8));
        // id_ready=0: four responses fill the buffer, then the request drops
        tbl.push_back(mk(1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 1, 1, A0, 0, 0));
        tbl.push_back(mk(0, 1, ~A0, 0, 0, 0, 1, 1, A0, 0, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 1, 1, A4, 1, A0));
        tbl.push_back(mk(0, 1, ~A4, 0, 0, 0, 1, 1, A4, 1, A0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 1, 1, A8, 1, A0));
        tbl.push_back(mk(0, 1, ~A8, 0, 0, 0, 1, 1, A8, 1, A0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 1, 1, AC, 1, A0));
        tbl.push_back(mk(0, 1, ~AC, 0, 0, 0, 1, 1, AC, 1, A0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 1, 0, 0,  1, A0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 1, 0, 0,  1, A0));
        // one-cycle pop of 0x40000000, refetch resumes at 0x40000010
        tbl.push_back(mk(0, 0, 0,   0, 0, 1, 1, 0, 0,  1, A0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 1, 1, A10, 1, A4));
        tbl.push_back(mk(0, 1, ~A10, 0, 0, 0, 1, 1, A10, 1, A4));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 1, 0, 0,  1, A4));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // ---------------- redirect during an outstanding request ----------
        do_reset(1'b0);
        cyc("rd_a0",   0, 0,  0, 0,  0, 1, A0, 0, 0);
        cyc("rd_a1",   1, A0, 0, 0,  0, 1, A0, 0, 0);
        cyc("rd_a2",   0, 0,  0, 0,  0, 1, A4, 1, A0);
        cyc("rd_a3",   1, A4, 0, 0,  0, 1, A4, 1, A0);
        cyc("rd_a4",   0, 0,  0, 0,  0, 1, A8, 1, A0);
        cyc("rd_redir",0, 0,  1, R1, 1, 1, A8, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc($sformatf("rd_wait%0d", i), 0, 0, 0, 0, 1, 1, A8, 0, 0);
        end
        cyc("rd_stale",1, A8, 0, 0,  1, 1, A8, 0, 0);
        cyc("rd_tgt",  0, 0,  0, 0,  0, 1, R1, 0, 0);
        cyc("rd_tresp",1, R1, 0, 0,  0, 1, R1, 0, 0);
        cyc("rd_tout", 0, 0,  0, 0,  0, 1, R1 + 32'd4, 1, R1);

        // ---------------- redirect together with the response -------------
        cyc("rr_both", 1, 32'h2152_4110, 1, R2, 0, 1, R1 + 32'd4, 0, 0);
        cyc("rr_tgt",  0, 0,  0, 0,  0, 1, R2, 0, 0);
        cyc("rr_resp", 1, R2, 0, 0,  0, 1, R2, 0, 0);
        cyc("rr_out",  0, 0,  0, 0,  0, 1, R2 + 32'd4, 1, R2);

        // ---------------- two redirects during one request ----------------
        cyc("r2_first",0, 0,  1, R3, 0, 1, R2 + 32'd4, 0, 0);
        cyc("r2_wait", 0, 0,  0, 0,  0, 1, R2 + 32'd4, 0, 0);
        cyc("r2_sec",  0, 0,  1, R4, 0, 1, R2 + 32'd4, 0, 0);
        cyc("r2_stale",1, R2 + 32'd4, 0, 0, 0, 1, R2 + 32'd4, 0, 0);
        cyc("r2_tgt",  0, 0,  0, 0,  0, 1, R4, 0, 0);
        cyc("r2_resp", 1, R4, 0, 0,  0, 1, R4, 0, 0);
        cyc("r2_out",  0, 0,  0, 0,  0, 1, R4 + 32'd4, 1, R4);

        // ---------------- reset mid-request -------------------------------
        do_reset(1'b0);
        cyc("rq_after",0, 0,  0, 0,  0, 1, A0, 0, 0);
`ifdef FETCH_PERF_EN
        check("rq perf_wait_cycles", perf_wait_cycles, 32'd0);
        check("rq perf_flush_count", perf_flush_count, 32'd0);
`endif
        cyc("rq_resp", 1, A0, 0, 0,  0, 1, A0, 0, 0);
        cyc("rq_out",  0, 0,  0, 0,  0, 1, A4, 1, A0);

        // ---------------- reset mid-flush ---------------------------------
        cyc("rf_redir",0, 0,  1, R1, 0, 1, A4, 0, 0);
        cyc("rf_flush",0, 0,  0, 0,  0, 1, A4, 0, 0);
`ifdef FETCH_PERF_EN
        check("rf perf_wait_cycles pre", perf_wait_cycles, 32'd3);
        check("rf perf_flush_count pre", perf_flush_count, 32'd1);
`endif
        do_reset(1'b0);
        cyc("rf_after",0, 0,  0, 0,  0, 1, A0, 0, 0);
`ifdef FETCH_PERF_EN
        check("rf perf_wait_cycles", perf_wait_cycles, 32'd0);
        check("rf perf_flush_count", perf_flush_count, 32'd0);
`endif
        cyc("rf_resp", 1, A0, 0, 0,  0, 1, A0, 0, 0);
        cyc("rf_out",  0, 0,  0, 0,  1, 1, A4, 1, A0);
        cyc("rf_empty",0, 0,  0, 0,  1, 1, A4, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
